pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_seq_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_reset_sequencer.sv | 106 ++++++++++
 tb/tb_pll_reset_sequencer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    // Width that holds every terminal count the shared counter ever reaches.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, waits for a stable lock, then releases the system reset;
// re-sequences on lock loss or lock timeout.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 100000
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] relock_count,
    output logic       timeout_err
);

    localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            locked_s;
    logic            lost, tmo;

    sync_2ff u_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        lost      = 1'b0;
        tmo       = 1'b0;
        case (state)
            PLL_RESET: begin
                if (cnt == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TMO_LAST) begin
                    state_nxt = PLL_RESET;
                    cnt_nxt   = '0;
                    tmo       = 1'b1;
                end
            end
            STABLE: begin
                // Lock loss takes priority over completing the stability window.
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STB_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                cnt_nxt = '0;
                if (!locked_s) begin
                    state_nxt = PLL_RESET;
                    lost      = 1'b1;
                end
            end
            default: begin
                state_nxt = PLL_RESET;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they move on the same edge as the state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state        <= PLL_RESET;
            cnt          <= '0;
            pll_rst      <= 1'b1;
            sys_rst      <= 1'b1;
            ready        <= 1'b0;
            relock_count <= 8'd0;
            timeout_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pll_rst <= (state_nxt == PLL_RESET);
            sys_rst <= (state_nxt != RUN);
            ready   <= (state_nxt == RUN);
            if (lost && relock_count != 8'hFF)
                relock_count <= relock_count + 8'd1;
            if (tmo)
                timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Table-driven bench for pll_reset_sequencer with small parameters.
module tb_pll_reset_sequencer;

    typedef struct packed {
        logic       pll_rst;
        logic       sys_rst;
        logic       ready;
        logic [7:0] relock;
        logic       terr;
    } out_t;

    typedef struct {
        bit   rst;
        bit   locked;
        int   n;
        out_t exp;
    } vec_t;

    logic       refclk = 1'b0;
    logic       rst    = 1'b1;
    logic       locked = 1'b0;
    logic       pll_rst, sys_rst, ready, timeout_err;
    logic [7:0] relock_count;

    int   checks   = 0;
    int   failures = 0;
    out_t sb_q[$];
    vec_t tbl[23];

    always #5 refclk = ~refclk;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .locked       (locked),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .relock_count (relock_count),
        .timeout_err  (timeout_err)
    );

    function automatic vec_t mk(input bit r, input bit l, input int n, input bit p,
                                input bit s, input bit rd, input int rel, input bit t);
        vec_t v;
        v.rst    = r;
        v.locked = l;
        v.n      = n;
        v.exp    = '{pll_rst: p, sys_rst: s, ready: rd, relock: rel[7:0], terr: t};
        return v;
    endfunction

    // Drive one record, hold it for n edges, then compare against the queued expectation.
    task automatic apply(input vec_t v, input string name);
        out_t e, got;
        rst    = v.rst;
        locked = v.locked;
        sb_q.push_back(v.exp);
        repeat (v.n) @(posedge refclk);
        #1;
        got = '{pll_rst: pll_rst, sys_rst: sys_rst, ready: ready, relock: relock_count, terr: timeout_err};
        e = sb_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s: pll_rst/sys_rst/ready/relock/terr got %b/%b/%b/%0d/%b exp %b/%b/%b/%0d/%b",
                     name, got.pll_rst, got.sys_rst, got.ready, got.relock, got.terr,
                     e.pll_rst, e.sys_rst, e.ready, e.relock, e.terr);
        end
    endtask

    task automatic lose_and_relock(input int rel_prev, input int rel_new, input bit t, input string name);
        apply(mk(0, 0, 2, 0, 0, 1, rel_prev, t), {name, "_hold"});
        apply(mk(0, 0, 1, 1, 1, 0, rel_new, t),  {name, "_fall"});
        apply(mk(0, 0, 4, 0, 1, 0, rel_new, t),  {name, "_pulse"});
        apply(mk(0, 1, 10, 0, 1, 0, rel_new, t), {name, "_stable"});
        apply(mk(0, 1, 1, 0, 0, 1, rel_new, t),  {name, "_run"});
    endtask

    initial begin
        int rel, rn;
        // reset and release
        tbl[0]  = mk(1, 0, 3,  1, 1, 0, 0, 0);
        tbl[1]  = mk(0, 0, 3,  1, 1, 0, 0, 0);
        tbl[2]  = mk(0, 0, 1,  0, 1, 0, 0, 0);
        // bring-up: 2 sync + 1 enter STABLE + 8 hold
        tbl[3]  = mk(0, 1, 10, 0, 1, 0, 0, 0);
        tbl[4]  = mk(0, 1, 1,  0, 0, 1, 0, 0);
        // lock loss in RUN
        tbl[5]  = mk(0, 0, 2,  0, 0, 1, 0, 0);
        tbl[6]  = mk(0, 0, 1,  1, 1, 0, 1, 0);
        tbl[7]  = mk(0, 0, 3,  1, 1, 0, 1, 0);
        tbl[8]  = mk(0, 0, 1,  0, 1, 0, 1, 0);
        // glitch mid-STABLE
        tbl[9]  = mk(0, 1, 6,  0, 1, 0, 1, 0);
        tbl[10] = mk(0, 0, 3,  0, 1, 0, 1, 0);
        tbl[11] = mk(0, 1, 10, 0, 1, 0, 1, 0);
        tbl[12] = mk(0, 1, 1,  0, 0, 1, 1, 0);
        // loss, then lock timeout and late lock
        tbl[13] = mk(0, 0, 2,  0, 0, 1, 1, 0);
        tbl[14] = mk(0, 0, 1,  1, 1, 0, 2, 0);
        tbl[15] = mk(0, 0, 3,  1, 1, 0, 2, 0);
        tbl[16] = mk(0, 0, 1,  0, 1, 0, 2, 0);
        tbl[17] = mk(0, 0, 31, 0, 1, 0, 2, 0);
        tbl[18] = mk(0, 0, 1,  1, 1, 0, 2, 1);
        tbl[19] = mk(0, 0, 3,  1, 1, 0, 2, 1);
        tbl[20] = mk(0, 0, 1,  0, 1, 0, 2, 1);
        tbl[21] = mk(0, 1, 10, 0, 1, 0, 2, 1);
        tbl[22] = mk(0, 1, 1,  0, 0, 1, 2, 1);

        for (int i = 0; i < 23; i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // 300 lock losses: count saturates at 255
        rel = 2;
        for (int i = 0; i < 300; i++) begin
            rn = (rel < 255) ? rel + 1 : 255;
            lose_and_relock(rel, rn, 1'b1, $sformatf("relock%0d", i));
            rel = rn;
        end

        apply(mk(1, 1, 1, 1, 1, 0, 0, 0), "rst_in_run_sat");
        apply(mk(0, 0, 4, 0, 1, 0, 0, 0), "rerelease");

        // lock lost on the very edge STABLE would complete
        apply(mk(0, 1, 8, 0, 1, 0, 0, 0), "edge_hold");
        apply(mk(0, 0, 3, 0, 1, 0, 0, 0), "edge_loss_wins");
        apply(mk(0, 1, 10, 0, 1, 0, 0, 0), "edge_restable");
        apply(mk(0, 1, 1, 0, 0, 1, 0, 0), "edge_run");

        for (int i = 0; i < 5; i++)
            lose_and_relock(i, i + 1, 1'b0, $sformatf("five%0d", i));

        apply(mk(1, 1, 1, 1, 1, 0, 0, 0), "rst_in_run_5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
